// File: rtl/foxtrot_pkg.sv
// Shared types and sizing for the writeback arbiter: geometry constants,
// the writeback payload record and the round-robin pointer increment.
package foxtrot_pkg;

  localparam int FU_COUNT     = 4;
  localparam int INST_ID_BITS = 6;
  localparam int PRN_BITS     = 6;
  localparam int MAX_OPERANDS = 3;
  localparam int DATA_BITS    = 64;
  localparam int FU_IDX_BITS  = $clog2(FU_COUNT);

  typedef struct packed {
    logic [INST_ID_BITS-1:0]                  inst_id;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]    prn;
    logic [MAX_OPERANDS-1:0][DATA_BITS-1:0]   data;
    logic [MAX_OPERANDS-1:0]                  data_valid;
  } wb_payload_t;

  // Pointer moves to the slot just after the winner, wrapping at FU_COUNT.
  function automatic logic [FU_IDX_BITS-1:0] rr_next(input logic [FU_IDX_BITS-1:0] idx);
    return (idx == FU_IDX_BITS'(FU_COUNT - 1)) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/fu_wb_arbiter_if.sv
// Bundle of FU result inputs, grants and the registered writeback bus.
// master = arbiter side, slave = FUs plus writeback consumer.
interface fu_wb_arbiter_if;
  import foxtrot_pkg::*;

  logic [FU_COUNT-1:0]     fu_in_valid;
  logic [INST_ID_BITS-1:0] fu_in_inst_id    [FU_COUNT];
  logic [PRN_BITS-1:0]     fu_in_prn        [FU_COUNT][MAX_OPERANDS];
  logic [DATA_BITS-1:0]    fu_in_data       [FU_COUNT][MAX_OPERANDS];
  logic [MAX_OPERANDS-1:0] fu_in_data_valid [FU_COUNT];
  logic [FU_COUNT-1:0]     fu_grant;

  logic                    wb_ready;
  logic                    wb_valid;
  logic [INST_ID_BITS-1:0] wb_inst_id;
  logic [PRN_BITS-1:0]     wb_prn  [MAX_OPERANDS];
  logic [DATA_BITS-1:0]    wb_data [MAX_OPERANDS];
  logic [MAX_OPERANDS-1:0] wb_data_valid;
  logic [FU_IDX_BITS-1:0]  wb_src_fu;

  modport master (
    input  fu_in_valid, fu_in_inst_id, fu_in_prn, fu_in_data, fu_in_data_valid, wb_ready,
    output fu_grant, wb_valid, wb_inst_id, wb_prn, wb_data, wb_data_valid, wb_src_fu
  );

  modport slave (
    output fu_in_valid, fu_in_inst_id, fu_in_prn, fu_in_data, fu_in_data_valid, wb_ready,
    input  fu_grant, wb_valid, wb_inst_id, wb_prn, wb_data, wb_data_valid, wb_src_fu
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or after ptr,
// wrapping modulo N. The pointer itself is owned by the caller.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  always_comb begin
    // NOTE: every output is assigned a default before the scan so no latch is inferred.
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[(int'(ptr) + k) % N]) begin
        any     = 1'b1;
        gnt_idx = IW'((int'(ptr) + k) % N);
      end
    end
    gnt[gnt_idx] = en & any;
  end

endmodule

// File: rtl/fu_wb_arbiter.sv
// Shares the writeback/wakeup/ROB-completion bus among the FUs: round-robin
// pick per cycle into a one-entry output stage with ready back-pressure.
module fu_wb_arbiter
  import foxtrot_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  fu_wb_arbiter_if.master bus
);

  logic                   stage_free;
  logic                   grant;
  logic                   any;
  logic [FU_COUNT-1:0]    gnt;
  logic [FU_IDX_BITS-1:0] gnt_idx;

  logic [FU_IDX_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic [FU_IDX_BITS-1:0] src_q, src_d;
  logic                   wb_valid_q, wb_valid_d;
  wb_payload_t            payload_q, payload_d;
  wb_payload_t            fu_payload [FU_COUNT];

  // Grants are suppressed while reset is asserted, not just at the next edge.
  assign stage_free = ~wb_valid_q | bus.wb_ready;
  assign grant      = any & stage_free & rst;

  rr_arbiter #(.N(FU_COUNT), .IW(FU_IDX_BITS)) u_rr (
    .req     (bus.fu_in_valid),
    .ptr     (rr_ptr_q),
    .en      (stage_free & rst),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign bus.fu_grant = gnt;

  always_comb begin
    for (int i = 0; i < FU_COUNT; i++) begin
      fu_payload[i].inst_id    = bus.fu_in_inst_id[i];
      fu_payload[i].data_valid = bus.fu_in_data_valid[i];
      for (int k = 0; k < MAX_OPERANDS; k++) begin
        fu_payload[i].prn[k]  = bus.fu_in_prn[i][k];
        fu_payload[i].data[k] = bus.fu_in_data[i][k];
      end
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    src_d      = src_q;
    wb_valid_d = wb_valid_q;
    payload_d  = payload_q;
    if (grant) begin
      rr_ptr_d   = rr_next(gnt_idx);
      src_d      = gnt_idx;
      wb_valid_d = 1'b1;
      payload_d  = fu_payload[gnt_idx];
    end else if (bus.wb_ready) begin
      wb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the payload register is reset too, so wb_* read as zero rather than X out of reset.
      rr_ptr_q   <= '0;
      src_q      <= '0;
      wb_valid_q <= 1'b0;
      payload_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      rr_ptr_q   <= rr_ptr_d;
      src_q      <= src_d;
      wb_valid_q <= wb_valid_d;
      payload_q  <= payload_d;
    end
  end

  assign bus.wb_valid      = wb_valid_q;
  assign bus.wb_inst_id    = payload_q.inst_id;
  assign bus.wb_src_fu     = src_q;
  assign bus.wb_data_valid = payload_q.data_valid & {MAX_OPERANDS{wb_valid_q}};

  always_comb begin
    for (int k = 0; k < MAX_OPERANDS; k++) begin
      bus.wb_prn[k]  = payload_q.prn[k];
      bus.wb_data[k] = payload_q.data[k];
    end
  end

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Self-checking bench for fu_wb_arbiter: directed scenarios with literal
// expectations plus a randomized run against a cycle-level reference model.
module tb_fu_wb_arbiter;
  import foxtrot_pkg::*;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  fu_wb_arbiter_if bus ();

  fu_wb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.fu_in_valid = '0;
    bus.wb_ready    = 1'b1;
    for (int i = 0; i < FU_COUNT; i++) begin
      bus.fu_in_inst_id[i]    = '0;
      bus.fu_in_data_valid[i] = '0;
      for (int k = 0; k < MAX_OPERANDS; k++) begin
        bus.fu_in_prn[i][k]  = '0;
        bus.fu_in_data[i][k] = '0;
      end
    end
  endtask

  task automatic set_fu(input int i, input logic [INST_ID_BITS-1:0] id,
                        input logic [PRN_BITS-1:0] prn0, input logic [DATA_BITS-1:0] d0,
                        input logic [MAX_OPERANDS-1:0] dv);
    bus.fu_in_valid[i]      = 1'b1;
    bus.fu_in_inst_id[i]    = id;
    bus.fu_in_prn[i][0]     = prn0;
    bus.fu_in_data[i][0]    = d0;
    bus.fu_in_data_valid[i] = dv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    bus.fu_in_valid = '1;
    #3;
    n_checks++; if (bus.fu_grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", bus.fu_grant); end
    n_checks++; if (bus.wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %b expected 0", bus.wb_valid); end
    n_checks++; if (bus.wb_data_valid !== 3'b000) begin n_fail++; $display("FAIL reset_data_valid: got %b expected 000", bus.wb_data_valid); end
    n_checks++; if (bus.wb_inst_id !== 6'd0) begin n_fail++; $display("FAIL reset_inst_id: got %0d expected 0", bus.wb_inst_id); end
    n_checks++; if (bus.wb_src_fu !== 2'd0) begin n_fail++; $display("FAIL reset_src_fu: got %0d expected 0", bus.wb_src_fu); end
    n_checks++; if (bus.wb_data[0] !== 64'd0 || bus.wb_prn[0] !== 6'd0) begin n_fail++; $display("FAIL reset_payload: got data %0h prn %0d expected 0", bus.wb_data[0], bus.wb_prn[0]); end
  endtask

  task automatic test_single();
    do_reset();
    set_fu(2, 6'd5, 6'd9, 64'hAB, 3'b001);
    #1;
    n_checks++; if (bus.fu_grant !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b expected 0100", bus.fu_grant); end
    tick();
    clear_inputs();
    n_checks++; if (bus.wb_valid !== 1'b1) begin n_fail++; $display("FAIL single_wb_valid: got %b expected 1", bus.wb_valid); end
    n_checks++; if (bus.wb_inst_id !== 6'd5) begin n_fail++; $display("FAIL single_inst_id: got %0d expected 5", bus.wb_inst_id); end
    n_checks++; if (bus.wb_prn[0] !== 6'd9) begin n_fail++; $display("FAIL single_prn0: got %0d expected 9", bus.wb_prn[0]); end
    n_checks++; if (bus.wb_data[0] !== 64'hAB) begin n_fail++; $display("FAIL single_data0: got %0h expected ab", bus.wb_data[0]); end
    n_checks++; if (bus.wb_src_fu !== 2'd2) begin n_fail++; $display("FAIL single_src_fu: got %0d expected 2", bus.wb_src_fu); end
    n_checks++; if (bus.wb_data_valid !== 3'b001) begin n_fail++; $display("FAIL single_data_valid: got %b expected 001", bus.wb_data_valid); end
  endtask

  task automatic test_rotation();
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < FU_COUNT; i++) set_fu(i, 6'(10 + i), 6'(i), 64'(100 + i), 3'b111);
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++; if (bus.fu_grant !== 4'(1 << order[c])) begin n_fail++; $display("FAIL rotation_grant[%0d]: got %b expected %b", c, bus.fu_grant, 4'(1 << order[c])); end
      tick();
      n_checks++; if (bus.wb_valid !== 1'b1 || bus.wb_src_fu !== 2'(order[c]) || bus.wb_inst_id !== 6'(10 + order[c]))
        begin n_fail++; $display("FAIL rotation_wb[%0d]: got v=%b src=%0d id=%0d expected v=1 src=%0d id=%0d", c, bus.wb_valid, bus.wb_src_fu, bus.wb_inst_id, order[c], 10 + order[c]); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    set_fu(0, 6'd20, 6'd1, 64'h20, 3'b011);
    tick();
    clear_inputs();
    bus.wb_ready = 1'b0;
    set_fu(1, 6'd21, 6'd2, 64'h21, 3'b101);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (bus.fu_grant !== 4'b0000) begin n_fail++; $display("FAIL stall_grant[%0d]: got %b expected 0000", c, bus.fu_grant); end
      tick();
      n_checks++; if (bus.wb_valid !== 1'b1 || bus.wb_inst_id !== 6'd20 || bus.wb_src_fu !== 2'd0 || bus.wb_data[0] !== 64'h20 || bus.wb_data_valid !== 3'b011)
        begin n_fail++; $display("FAIL stall_hold[%0d]: got v=%b id=%0d src=%0d d=%0h dv=%b expected v=1 id=20 src=0 d=20 dv=011", c, bus.wb_valid, bus.wb_inst_id, bus.wb_src_fu, bus.wb_data[0], bus.wb_data_valid); end
    end
    bus.wb_ready = 1'b1;
    #1;
    n_checks++; if (bus.fu_grant !== 4'b0010) begin n_fail++; $display("FAIL stall_release_grant: got %b expected 0010", bus.fu_grant); end
    tick();
    bus.fu_in_valid[1] = 1'b0;
    n_checks++; if (bus.wb_valid !== 1'b1 || bus.wb_inst_id !== 6'd21 || bus.wb_src_fu !== 2'd1)
      begin n_fail++; $display("FAIL stall_release_wb: got v=%b id=%0d src=%0d expected v=1 id=21 src=1", bus.wb_valid, bus.wb_inst_id, bus.wb_src_fu); end
  endtask

  task automatic test_pointer();
    do_reset();
    set_fu(2, 6'd30, 6'd0, 64'd0, 3'b001);
    tick();
    clear_inputs();
    set_fu(0, 6'd31, 6'd0, 64'd0, 3'b001);
    set_fu(3, 6'd33, 6'd0, 64'd0, 3'b001);
    #1;
    n_checks++; if (bus.fu_grant !== 4'b1000) begin n_fail++; $display("FAIL pointer_tie_grant: got %b expected 1000", bus.fu_grant); end
    tick();
    bus.fu_in_valid[3] = 1'b0;
    #1;
    n_checks++; if (bus.fu_grant !== 4'b0001) begin n_fail++; $display("FAIL pointer_wrap_grant: got %b expected 0001", bus.fu_grant); end
    n_checks++; if (bus.wb_src_fu !== 2'd3 || bus.wb_inst_id !== 6'd33) begin n_fail++; $display("FAIL pointer_wb3: got src=%0d id=%0d expected src=3 id=33", bus.wb_src_fu, bus.wb_inst_id); end
    tick();
    bus.fu_in_valid[0] = 1'b0;
    n_checks++; if (bus.wb_src_fu !== 2'd0 || bus.wb_inst_id !== 6'd31) begin n_fail++; $display("FAIL pointer_wb0: got src=%0d id=%0d expected src=0 id=31", bus.wb_src_fu, bus.wb_inst_id); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_fu(1, 6'd7, 6'd3, 64'h7, 3'b111);
    tick();
    clear_inputs();
    bus.wb_ready = 1'b0;
    n_checks++; if (bus.wb_valid !== 1'b1 || bus.wb_inst_id !== 6'd7) begin n_fail++; $display("FAIL rststall_held: got v=%b id=%0d expected v=1 id=7", bus.wb_valid, bus.wb_inst_id); end
    set_fu(0, 6'd40, 6'd0, 64'd0, 3'b001);
    set_fu(2, 6'd42, 6'd0, 64'd0, 3'b001);
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (bus.wb_valid !== 1'b0 || bus.wb_inst_id !== 6'd0 || bus.wb_data_valid !== 3'b000)
      begin n_fail++; $display("FAIL rststall_async_clear: got v=%b id=%0d dv=%b expected v=0 id=0 dv=000", bus.wb_valid, bus.wb_inst_id, bus.wb_data_valid); end
    n_checks++; if (bus.fu_grant !== 4'b0000) begin n_fail++; $display("FAIL rststall_grant_in_reset: got %b expected 0000", bus.fu_grant); end
    #1;
    rst = 1'b1;
    bus.wb_ready = 1'b1;
    #1;
    n_checks++; if (bus.fu_grant !== 4'b0001) begin n_fail++; $display("FAIL rststall_tie_after: got %b expected 0001", bus.fu_grant); end
    tick();
    bus.fu_in_valid[0] = 1'b0;
    #1;
    n_checks++; if (bus.wb_src_fu !== 2'd0 || bus.wb_inst_id !== 6'd40 || bus.fu_grant !== 4'b0100)
      begin n_fail++; $display("FAIL rststall_next: got src=%0d id=%0d gnt=%b expected src=0 id=40 gnt=0100", bus.wb_src_fu, bus.wb_inst_id, bus.fu_grant); end
  endtask

  task automatic test_idle_drain();
    do_reset();
    set_fu(3, 6'd50, 6'd5, 64'h55, 3'b111);
    tick();
    clear_inputs();
    n_checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data_valid !== 3'b111) begin n_fail++; $display("FAIL drain_first: got v=%b dv=%b expected v=1 dv=111", bus.wb_valid, bus.wb_data_valid); end
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++; if (bus.wb_valid !== 1'b0 || bus.wb_data_valid !== 3'b000 || bus.fu_grant !== 4'b0000)
        begin n_fail++; $display("FAIL drain_idle[%0d]: got v=%b dv=%b gnt=%b expected v=0 dv=000 gnt=0000", c, bus.wb_valid, bus.wb_data_valid, bus.fu_grant); end
    end
  endtask

  task automatic test_random();
    int                      m_ptr = 0;
    int                      m_src = 0;
    bit                      m_valid = 1'b0;
    logic [INST_ID_BITS-1:0] m_id = '0;
    logic [MAX_OPERANDS-1:0] m_dv = '0;
    logic [PRN_BITS-1:0]     m_prn  [MAX_OPERANDS] = '{default: '0};
    logic [DATA_BITS-1:0]    m_data [MAX_OPERANDS] = '{default: '0};
    int                      win;
    logic [FU_COUNT-1:0]     exp_gnt;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < FU_COUNT; i++) begin
        bus.fu_in_valid[i]      = ($urandom_range(0, 99) < 55);
        bus.fu_in_inst_id[i]    = INST_ID_BITS'($urandom);
        bus.fu_in_data_valid[i] = MAX_OPERANDS'($urandom);
        for (int k = 0; k < MAX_OPERANDS; k++) begin
          bus.fu_in_prn[i][k]  = PRN_BITS'($urandom);
          bus.fu_in_data[i][k] = {$urandom, $urandom};
        end
      end
      bus.wb_ready = ($urandom_range(0, 99) < 70);
      #1;
      win = -1;
      if (!m_valid || bus.wb_ready)
        for (int k = 0; k < FU_COUNT; k++)
          if (win < 0 && bus.fu_in_valid[(m_ptr + k) % FU_COUNT]) win = (m_ptr + k) % FU_COUNT;
      exp_gnt = (win >= 0) ? FU_COUNT'(1 << win) : '0;
      n_checks++; if (bus.fu_grant !== exp_gnt) begin n_fail++; $display("FAIL rand_grant[%0d]: got %b expected %b", c, bus.fu_grant, exp_gnt); end
      @(posedge clk);
      if (win >= 0) begin
        m_valid = 1'b1;
        m_src   = win;
        m_ptr   = (win + 1) % FU_COUNT;
        m_id    = bus.fu_in_inst_id[win];
        m_dv    = bus.fu_in_data_valid[win];
        for (int k = 0; k < MAX_OPERANDS; k++) begin
          m_prn[k]  = bus.fu_in_prn[win][k];
          m_data[k] = bus.fu_in_data[win][k];
        end
      end else if (bus.wb_ready) begin
        m_valid = 1'b0;
      end
      #1;
      n_checks++; if (bus.wb_valid !== m_valid || bus.wb_inst_id !== m_id || bus.wb_src_fu !== FU_IDX_BITS'(m_src))
        begin n_fail++; $display("FAIL rand_wb_ctrl[%0d]: got v=%b id=%0d src=%0d expected v=%b id=%0d src=%0d", c, bus.wb_valid, bus.wb_inst_id, bus.wb_src_fu, m_valid, m_id, m_src); end
      n_checks++; if (bus.wb_data_valid !== (m_valid ? m_dv : 3'b000))
        begin n_fail++; $display("FAIL rand_wb_dv[%0d]: got %b expected %b", c, bus.wb_data_valid, m_valid ? m_dv : 3'b000); end
      for (int k = 0; k < MAX_OPERANDS; k++) begin
        n_checks++; if (bus.wb_prn[k] !== m_prn[k] || bus.wb_data[k] !== m_data[k])
          begin n_fail++; $display("FAIL rand_wb_lane[%0d][%0d]: got prn=%0d data=%0h expected prn=%0d data=%0h", c, k, bus.wb_prn[k], bus.wb_data[k], m_prn[k], m_data[k]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_stall();
    test_pointer();
    test_reset_mid_stall();
    test_idle_drain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
